// File: rtl/gate_sequencer.sv
// Lane barrier motor sequencer: limit-switch homing, obstruction reversal, dead time, travel timeout.
// Moore outputs, one cycle from sampled input to output; no backpressure, commands are level/pulse inputs.
module gate_sequencer #(
    parameter int MOVE_TIMEOUT = 1000,
    parameter int DEAD_CYCLES  = 16,
    parameter int TW           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic up_req,
    input  logic down_req,
    input  logic limit_top,
    input  logic limit_bot,
    input  logic obstruct,
    input  logic clr_fault,
    output logic motor_up,
    output logic motor_down,
    output logic gate_open,
    output logic gate_closed,
    output logic fault
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_CLOSED,
        ST_OPENING,
        ST_OPEN,
        ST_CLOSING,
        ST_REVERSE,
        ST_FAULT
    } state_t;

    localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_TIMEOUT - 1);
    localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CYCLES - 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            close_pend_q, close_pend_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            timer_q      <= '0;
            close_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            close_pend_q <= close_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        close_pend_d = close_pend_q;
        if (state_q != ST_FAULT && limit_top && limit_bot) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (obstruct)       state_d = ST_INIT;
                    else if (limit_bot) state_d = ST_CLOSED;
                    else                state_d = ST_CLOSING;
                end
                ST_CLOSED: begin
                    if (up_req) state_d = ST_OPENING;
                end
                ST_OPENING: begin
                    if (limit_top)                 state_d = ST_OPEN;
                    else if (timer_q == MOVE_LAST) state_d = ST_FAULT;
                    if (up_req)        close_pend_d = 1'b0;
                    else if (down_req) close_pend_d = 1'b1;
                end
                ST_OPEN: begin
                    if (up_req) begin
                        close_pend_d = 1'b0;
                    end else if (obstruct) begin
                        // Hold the close request until the lane is clear.
                        close_pend_d = close_pend_q | down_req;
                    end else if (down_req || close_pend_q) begin
                        state_d      = ST_CLOSING;
                        close_pend_d = 1'b0;
                    end
                end
                ST_CLOSING: begin
                    if (limit_bot) begin
                        state_d = ST_CLOSED;
                    end else if (up_req) begin
                        state_d      = ST_REVERSE;
                        close_pend_d = 1'b0;
                    end else if (obstruct) begin
                        state_d      = ST_REVERSE;
                        close_pend_d = 1'b1;
                    end else if (timer_q == MOVE_LAST) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_REVERSE: begin
                    if (timer_q == DEAD_LAST) state_d = ST_OPENING;
                    if (up_req)        close_pend_d = 1'b0;
                    else if (down_req) close_pend_d = 1'b1;
                end
                ST_FAULT: begin
                    close_pend_d = 1'b0;
                    if (clr_fault) state_d = ST_INIT;
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // Timer measures time spent in the current state; it saturates so a stalled travel never wraps.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == ST_OPENING || state_q == ST_CLOSING || state_q == ST_REVERSE)
                     && timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_comb begin
        motor_up    = 1'b0;
        motor_down  = 1'b0;
        gate_open   = 1'b0;
        gate_closed = 1'b0;
        fault       = 1'b0;
        case (state_q)
            ST_OPENING: motor_up    = 1'b1;
            ST_CLOSING: motor_down  = 1'b1;
            ST_OPEN:    gate_open   = 1'b1;
            ST_CLOSED:  gate_closed = 1'b1;
            ST_FAULT:   fault       = 1'b1;
            default:    ;
        endcase
    end

endmodule
